// File: rtl/ra_pq_s_if.sv
// Shared types and the bus interface for the register-array priority queue.
// pq_pkg fixes the entry format; pq_rd_if carries the request/response
// signals between a host and the queue (the dev modport is the queue side).

package pq_pkg;
   localparam int KEY_WIDTH   = 8;
   localparam int VAL_WIDTH   = 8;
   localparam int PQ_CAPACITY = 16;

   // Lower key means higher priority; the value rides along untouched
   typedef struct packed {
      logic [KEY_WIDTH-1:0] key;
      logic [VAL_WIDTH-1:0] value;
   } kv_t;
endpackage

interface pq_rd_if;
   import pq_pkg::*;

   logic enq;
   logic deq;
   kv_t  kvi;
   kv_t  kvo;
   logic busy;
   logic full;
   logic empty;
   logic err;

   modport dev (
      input  enq,
      input  deq,
      input  kvi,
      output kvo,
      output busy,
      output full,
      output empty,
      output err
   );

   modport host (
      output enq,
      output deq,
      output kvi,
      input  kvo,
      input  busy,
      input  full,
      input  empty,
      input  err
   );
endinterface

// File: rtl/ra_pq_s.sv
// ra_pq_s: priority queue built from an unsorted register array.
// Enqueue appends in one cycle and updates the minimum pointer on the fly;
// dequeue and replace punch a hole at the minimum, refill it, then rescan
// the array one entry per cycle to find the new minimum (busy meanwhile).
// Optional build macro RA_PQ_S_ERRFLAG_EN adds a sticky err flag that sets
// on every ignored request; without it err is tied low.

module ra_pq_s
   import pq_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   pq_rd_if.dev     pq
);

   // Count needs one more code than there are slots so "full" is encodable
   localparam int CW = $clog2(PQ_CAPACITY + 1);
   localparam int IW = (PQ_CAPACITY > 2) ? $clog2(PQ_CAPACITY) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   kv_t                  mem [PQ_CAPACITY];
   logic [CW-1:0]        count;
   logic [IW-1:0]        min_idx;
   logic [0:0]           state;
   logic [IW-1:0]        scan_idx;
   logic [IW-1:0]        best_idx;
   logic [KEY_WIDTH-1:0] best_key;

   logic                 idle;
   logic                 is_empty;
   logic                 is_full;
   logic                 acc_enq;
   logic                 acc_deq;
   logic                 acc_rep;
   logic                 start_scan;
   logic [IW-1:0]        last_idx;
   logic [IW-1:0]        wr_idx;
   kv_t                  head;
   kv_t                  cand;
   logic                 take;
   logic [IW-1:0]        next_best_idx;
   logic                 scan_done;

   // Status decodes and request acceptance, all straight from current state
   always_comb begin
      idle     = (state == ST_IDLE);
      is_empty = (count == '0);
      is_full  = (count == CW'(PQ_CAPACITY));
      head     = mem[min_idx];
      last_idx = IW'(count - CW'(1));
      wr_idx   = IW'(count);

      // enq+deq on an empty queue degenerates into a plain enqueue
      acc_enq  = idle & pq.enq & (~pq.deq | is_empty) & ~is_full;
      acc_deq  = idle & pq.deq & ~pq.enq & ~is_empty;
      acc_rep  = idle & pq.deq & pq.enq & ~is_empty;

      // Removing the last entry leaves nothing to scan
      start_scan = acc_rep | (acc_deq & (count != CW'(1)));
   end

   // One step of the running-minimum search; strict less-than keeps the lowest index on ties
   always_comb begin
      cand          = mem[scan_idx];
      take          = (scan_idx == '0) || (cand.key < best_key);
      next_best_idx = take ? scan_idx : best_idx;
      scan_done     = (scan_idx == last_idx);
   end

   // Entry storage: append on enqueue, fill the minimum's slot on dequeue/replace
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PQ_CAPACITY; i++) begin
            mem[i] <= '0;
         end
      end else if (acc_enq) begin
         mem[wr_idx] <= pq.kvi;
      end else if (acc_deq) begin
         mem[min_idx] <= mem[last_idx];
      end else if (acc_rep) begin
         mem[min_idx] <= pq.kvi;
      end
   end

   // Occupancy counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (acc_enq) begin
         count <= count + CW'(1);
      end else if (acc_deq) begin
         count <= count - CW'(1);
      end
   end

   // Minimum pointer: tracked incrementally on enqueue, rewritten at the end of a rescan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_idx <= '0;
      end else if (acc_enq) begin
         if (is_empty || (pq.kvi.key < head.key)) begin
            min_idx <= wr_idx;
         end
      end else if ((state == ST_SCAN) && scan_done) begin
         min_idx <= next_best_idx;
      end
   end

   // Rescan sequencer: walks indices 0..count-1, one per cycle, holding busy high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         scan_idx <= '0;
         best_idx <= '0;
         best_key <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_scan) begin
                  state    <= ST_SCAN;
                  scan_idx <= '0;
               end
            end
            ST_SCAN: begin
               best_idx <= next_best_idx;
               if (take) begin
                  best_key <= cand.key;
               end
               if (scan_done) begin
                  state <= ST_IDLE;
               end else begin
                  scan_idx <= scan_idx + IW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output drive: an empty queue presents an all-zero entry
   always_comb begin
      pq.kvo   = is_empty ? '0 : head;
      pq.busy  = (state == ST_SCAN);
      pq.full  = is_full;
      pq.empty = is_empty;
   end

`ifdef RA_PQ_S_ERRFLAG_EN
   logic ignored;
   logic err_q;

   // Any request not accepted this cycle counts as ignored
   always_comb begin
      ignored = (pq.enq | pq.deq) & ~acc_enq & ~acc_deq & ~acc_rep;
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (ignored) begin
         err_q <= 1'b1;
      end
   end

   assign pq.err = err_q;
`else
   assign pq.err = 1'b0;
`endif

endmodule

// File: tb/tb_ra_pq_s.sv
// Self-checking bench for ra_pq_s: directed scenarios plus a randomized run
// against a queue-based reference model of the priority queue.

module tb_ra_pq_s;
   import pq_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   // Reference model: entries in slot order, plus the sticky error flag
   kv_t  m_mem[$];
   bit   m_err;

   pq_rd_if bus ();

   ra_pq_s dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pq    (bus)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges the run
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic kv_t mk(input int k, input int v);
      kv_t r;
      r.key   = 8'(k);
      r.value = 8'(v);
      return r;
   endfunction

   // Slot of the smallest key, earliest slot winning ties; -1 when empty
   function automatic int m_min();
      int b;
      b = -1;
      foreach (m_mem[i]) begin
         if (b < 0 || m_mem[i].key < m_mem[b].key) b = i;
      end
      return b;
   endfunction

   function automatic kv_t m_head();
      kv_t r;
      r = '0;
      if (m_mem.size() > 0) r = m_mem[m_min()];
      return r;
   endfunction

   function automatic bit m_exp_err();
`ifdef RA_PQ_S_ERRFLAG_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   // Apply one idle-time request to the model; scan = expected busy cycles
   task automatic m_apply(input bit e, input bit d, input kv_t kv, output int scan);
      int mi;
      scan = 0;
      if (e && (!d || m_mem.size() == 0)) begin
         if (m_mem.size() < PQ_CAPACITY) m_mem.push_back(kv);
         else m_err = 1'b1;
      end else if (e && d) begin
         m_mem[m_min()] = kv;
         scan = m_mem.size();
      end else if (d) begin
         if (m_mem.size() == 0) begin
            m_err = 1'b1;
         end else begin
            mi = m_min();
            m_mem[mi] = m_mem[m_mem.size() - 1];
            void'(m_mem.pop_back());
            scan = m_mem.size();
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request for one edge, then return inputs to idle
   task automatic issue(input bit e, input bit d, input kv_t kv, output int scan);
      bus.enq = e;
      bus.deq = d;
      bus.kvi = kv;
      tick();
      bus.enq = 1'b0;
      bus.deq = 1'b0;
      bus.kvi = '0;
      m_apply(e, d, kv, scan);
   endtask

   // Count cycles with busy high, giving up after 40
   task automatic run_scan(output int n);
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic do_reset();
      bus.enq = 1'b0;
      bus.deq = 1'b0;
      bus.kvi = '0;
      rst_n   = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      m_mem.delete();
      m_err = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.kvo !== kv_t'('0)) begin errors++; $display("[TB] FAIL reset_kvo: got %h expected 0000", bus.kvo); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
   endtask

   task automatic test_basic();
      int s;
      int n;
      int keys[3] = '{30, 10, 20};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b0, mk(keys[i], i + 1), s);
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_enq_busy%0d: got %b expected 0", i, bus.busy); end
      end
      checks++; if (bus.kvo !== mk(10, 2)) begin errors++; $display("[TB] FAIL basic_head: got %h expected %h", bus.kvo, mk(10, 2)); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty: got %b expected 0", bus.empty); end
      issue(1'b0, 1'b1, '0, s);
      run_scan(n);
      checks++; if (n !== 2) begin errors++; $display("[TB] FAIL basic_scan1_len: got %0d expected 2", n); end
      checks++; if (bus.kvo !== mk(20, 3)) begin errors++; $display("[TB] FAIL basic_deq1: got %h expected %h", bus.kvo, mk(20, 3)); end
      issue(1'b0, 1'b1, '0, s);
      run_scan(n);
      checks++; if (n !== 1) begin errors++; $display("[TB] FAIL basic_scan2_len: got %0d expected 1", n); end
      checks++; if (bus.kvo !== mk(30, 1)) begin errors++; $display("[TB] FAIL basic_deq2: got %h expected %h", bus.kvo, mk(30, 1)); end
      issue(1'b0, 1'b1, '0, s);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_deq3_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_deq3_empty: got %b expected 1", bus.empty); end
      checks++; if (bus.kvo !== kv_t'('0)) begin errors++; $display("[TB] FAIL basic_deq3_kvo: got %h expected 0000", bus.kvo); end
   endtask

   task automatic test_full();
      int s;
      int n;
      do_reset();
      for (int k = 16; k >= 1; k--) issue(1'b1, 1'b0, mk(k, k + 100), s);
      checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", bus.full); end
      checks++; if (bus.kvo.key !== 8'd1) begin errors++; $display("[TB] FAIL full_head: got %0d expected 1", bus.kvo.key); end
      issue(1'b1, 1'b0, mk(0, 55), s);
      checks++; if (bus.kvo.key !== 8'd1) begin errors++; $display("[TB] FAIL full_extra_ignored: got %0d expected 1", bus.kvo.key); end
      checks++; if (bus.err !== m_exp_err()) begin errors++; $display("[TB] FAIL full_err: got %b expected %b", bus.err, m_exp_err()); end
      issue(1'b1, 1'b1, mk(0, 66), s);
      run_scan(n);
      checks++; if (n !== 16) begin errors++; $display("[TB] FAIL full_rep_scan: got %0d expected 16", n); end
      checks++; if (bus.kvo !== mk(0, 66)) begin errors++; $display("[TB] FAIL full_rep_head: got %h expected %h", bus.kvo, mk(0, 66)); end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL full_rep_full: got %b expected 1", bus.full); end
   endtask

   task automatic test_ties();
      int s;
      int n;
      do_reset();
      for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, mk(5, 7 + i), s);
      checks++; if (bus.kvo !== mk(5, 7)) begin errors++; $display("[TB] FAIL ties_head: got %h expected %h", bus.kvo, mk(5, 7)); end
      issue(1'b0, 1'b1, '0, s);
      run_scan(n);
      checks++; if (n !== 2) begin errors++; $display("[TB] FAIL ties_scan: got %0d expected 2", n); end
      checks++; if (bus.kvo !== mk(5, 9)) begin errors++; $display("[TB] FAIL ties_after_deq: got %h expected %h", bus.kvo, mk(5, 9)); end
   endtask

   task automatic test_busy_and_reset();
      int s;
      int n;
      int keys[3] = '{30, 10, 20};
      do_reset();
      for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, mk(keys[i], i + 1), s);
      issue(1'b0, 1'b1, '0, s);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_start: got %b expected 1", bus.busy); end
      bus.deq = 1'b1;
      tick();
      bus.deq = 1'b0;
      m_err = 1'b1;
      run_scan(n);
      checks++; if (n !== 1) begin errors++; $display("[TB] FAIL busy_len_with_req: got %0d more cycles expected 1", n); end
      checks++; if (bus.kvo !== mk(20, 3)) begin errors++; $display("[TB] FAIL busy_ignored_head: got %h expected %h", bus.kvo, mk(20, 3)); end
      checks++; if (bus.err !== m_exp_err()) begin errors++; $display("[TB] FAIL busy_err: got %b expected %b", bus.err, m_exp_err()); end
      issue(1'b0, 1'b1, '0, s);
      run_scan(n);
      checks++; if (n !== 1) begin errors++; $display("[TB] FAIL busy_count_kept: got %0d expected 1", n); end
      checks++; if (bus.kvo !== mk(30, 1)) begin errors++; $display("[TB] FAIL busy_next_head: got %h expected %h", bus.kvo, mk(30, 1)); end
      for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, mk(40 - i, i), s);
      issue(1'b0, 1'b1, '0, s);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midscan_reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL midscan_reset_empty: got %b expected 1", bus.empty); end
      checks++; if (bus.kvo !== kv_t'('0)) begin errors++; $display("[TB] FAIL midscan_reset_kvo: got %h expected 0000", bus.kvo); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL midscan_reset_err: got %b expected 0", bus.err); end
      @(negedge clk);
      rst_n = 1'b1;
      m_mem.delete();
      m_err = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL after_reset_idle: got busy=%b empty=%b expected 0/1", bus.busy, bus.empty); end
   endtask

   task automatic test_random();
      int s;
      int n;
      int extra;
      int r;
      bit e;
      bit d;
      do_reset();
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         e = (r < 5) || (r >= 8);
         d = (r >= 5);
         issue(e, d, mk($urandom_range(0, 20), $urandom_range(0, 255)), s);
         extra = 0;
         if (bus.busy && $urandom_range(0, 3) == 0) begin
            bus.enq = $urandom_range(0, 1);
            bus.deq = 1'b1;
            tick();
            bus.enq = 1'b0;
            bus.deq = 1'b0;
            m_err = 1'b1;
            extra = 1;
         end
         run_scan(n);
         checks++; if (n + extra !== s) begin errors++; $display("[TB] FAIL rand_scan_len it=%0d: got %0d expected %0d", it, n + extra, s); end
         checks++; if (bus.kvo !== m_head()) begin errors++; $display("[TB] FAIL rand_head it=%0d: got %h expected %h", it, bus.kvo, m_head()); end
         checks++; if (bus.empty !== (m_mem.size() == 0) || bus.full !== (m_mem.size() == PQ_CAPACITY)) begin
            errors++; $display("[TB] FAIL rand_flags it=%0d: got empty=%b full=%b expected size %0d", it, bus.empty, bus.full, m_mem.size());
         end
         checks++; if (bus.err !== m_exp_err()) begin errors++; $display("[TB] FAIL rand_err it=%0d: got %b expected %b", it, bus.err, m_exp_err()); end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      errors  = 0;
      checks  = 0;
      m_err   = 1'b0;
      rst_n   = 1'b0;
      bus.enq = 1'b0;
      bus.deq = 1'b0;
      bus.kvi = '0;
      test_reset();
      test_basic();
      test_full();
      test_ties();
      test_busy_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ra_pq_s.md
RA_PQ_S -- requirements
Module: ra_pq_s

Interface
REQ-001 The block SHALL connect through a single pq_rd_if modport (dev); all ports below are members of that interface.
REQ-002 KEY_WIDTH, 8, key bits per entry (from pq_pkg); lower key = higher priority.
REQ-003 VAL_WIDTH, 8, value bits per entry (from pq_pkg).
REQ-004 PQ_CAPACITY, 16, number of entries (from pq_pkg); SHALL be at least 2.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enq  in  1  enqueue request, sampled on rising clk.
REQ-008 deq  in  1  dequeue request, sampled on rising clk.
REQ-009 kvi  in  KEY_WIDTH+VAL_WIDTH  entry to enqueue, packed {key,value} (pq_pkg kv_t).
REQ-010 kvo  out  KEY_WIDTH+VAL_WIDTH  current highest-priority entry, packed {key,value}.
REQ-011 busy  out  1  high while a rescan is in progress; requests ignored.
REQ-012 full  out  1  high when count == PQ_CAPACITY.
REQ-013 empty  out  1  high when count == 0.
REQ-014 err  out  1  sticky error flag; see Configuration.

Function
REQ-015 Storage SHALL be an unsorted register array mem[0..PQ_CAPACITY-1], a count register, and a min_idx register pointing at the minimum-key entry.
REQ-016 kvo SHALL equal mem[min_idx] when !empty and !busy, and 0 when empty; kvo is don't-care while busy.
REQ-017 Enqueue only (enq & !deq & !busy & !full): mem[count] <= kvi, count += 1; if empty or kvi.key < kvo.key, min_idx <= old count; completes in 1 cycle with busy staying 0.
REQ-018 Dequeue only (deq & !enq & !busy & !empty): mem[min_idx] <= mem[count-1], count -= 1; if the new count > 0, a rescan SHALL start, otherwise busy stays 0 and empty rises.
REQ-019 Replace (enq & deq & !busy & !empty): mem[min_idx] <= kvi, count unchanged, rescan SHALL start; replace is accepted even when full.
REQ-020 enq & deq while empty SHALL act as enqueue only.
REQ-021 Rescan: busy=1 from the accepting edge; one index is examined per cycle from 0 to count-1 with a running minimum. After the last index, min_idx is updated and busy drops, so busy stays high for exactly count cycles.
REQ-022 Rescan tie-break: strict less-than, so the lowest index among equal keys SHALL win.
REQ-023 Requests while busy, enq while full (without deq), or deq while empty SHALL be ignored with no state change.
REQ-024 full and empty SHALL be combinational decodes of count; count SHALL never exceed PQ_CAPACITY or go below 0.

Reset
REQ-025 On rst_n low, immediately and asynchronously: count=0, min_idx=0, all mem=0, scan state idle, busy=0, err=0. Hence kvo=0, empty=1, full=0.
REQ-026 Reset asserted mid-rescan SHALL abort the scan and discard all contents.

Configuration
REQ-027 Macro RA_PQ_S_ERRFLAG_EN: when defined, err SHALL set on any ignored request per REQ-023 and hold until reset. When undefined, err SHALL be tied to 0 and no error logic is built.

Verification
REQ-028 Reset, then enq keys 30,10,20 (values 1,2,3) on three consecutive cycles -> kvo={10,2}, busy never high, empty=0.
REQ-029 From REQ-028, deq -> busy high exactly 2 cycles, then kvo={20,3}, count=2; deq again -> busy 1 cycle, kvo={30,1}; deq -> empty=1, kvo=0, busy stays 0.
REQ-030 Fill 16 entries with keys 16..1 -> full=1, kvo key=1; an extra enq of key 0 is ignored (err=1 with macro, err=0 without); enq+deq of key 0 -> kvo key=0 after 16 busy cycles, full still 1.
REQ-031 Enq keys 5,5,5 with values 7,8,9 -> kvo={5,7}; deq then wait for !busy -> kvo={5,9}, because the last entry moves into the hole at index 0 and wins the tie.
REQ-032 Issue deq during busy -> ignored, count unchanged; assert rst_n low mid-rescan -> busy=0, empty=1, kvo=0 without waiting for a clock edge.
